// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and small op-classification helpers.
package md_defs;

  // md_op encodings; 6 and 7 both mean "no operation"
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NONE  = 3'd6
  } md_op_e;

  // Sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Default busy-window lengths (legal range 1..15 each)
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int CNT_W           = 4;

  // True for the four ops that open a busy window
  function automatic logic is_start_op(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

  // True for mult/multu
  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purely combinational multiply/divide datapath. Produces the HI/LO pair for
// the requested op and flags divide-by-zero so the controller can skip commit.
module mdu_arith
  import md_defs::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  md_op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_ovf;
  logic [31:0]        b_safe;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;

  // Sign-extending to 64 bits makes the truncated 64-bit product the exact signed result
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // The one signed overflow case (-2^31 / -1) and b=0 are steered away from the
  // divider so it never sees an undefined operand pair; results are muxed below.
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_safe  = ((b == 32'd0) || div_ovf) ? 32'd1 : b;

  assign quo_s = $signed(a) / $signed(b_safe);
  assign rem_s = $signed(a) % $signed(b_safe);
  assign quo_u = a / b_safe;
  assign rem_u = a % b_safe;

  // Select result for the requested op
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    div0   = 1'b0;
    case (md_op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        div0 = (b == 32'd0);
        if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      MD_DIVU: begin
        div0   = (b == 32'd0);
        res_hi = rem_u;
        res_lo = quo_u;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller. A legal start in IDLE captures the arith
// result into pending registers and opens a fixed busy window; HI/LO are
// written when the window closes. mthi/mtlo write HI/LO directly while idle.
//
// Handshake: there is no ready. The D-stage hazard unit holds every MD-class
// instruction while start|busy is high, so start and md_we are only expected
// while busy=0; anything arriving during RUN is dropped (and flagged in sim).
module mdu_ctrl
  import md_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        md_we,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata,
  output md_state_e   dbg_state
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        start_ok;
  logic        commit;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div0;

  mdu_arith u_arith (
    .a      (a),
    .b      (b),
    .md_op  (md_op),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (div0)
  );

  assign start_ok = start && is_start_op(md_op);
  assign commit   = (state_q == ST_RUN) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q == ST_RUN);
    dbg_state = state_q;
  end

  // Datapath next values: capture on start, count down, commit or direct write
  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (state_q == ST_IDLE) begin
      if (start_ok) begin
        pend_hi_d = res_hi;
        pend_lo_d = res_lo;
        // A divide by zero still runs its window but leaves HI/LO untouched
        pend_wr_d = !div0;
        cnt_d     = is_mul_op(md_op) ? MULT_LOAD : DIV_LOAD;
      end else if (md_we && (md_op == MD_MTHI)) begin
        hi_d = a;
      end else if (md_we && (md_op == MD_MTLO)) begin
        lo_d = a;
      end
    end else begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  // During RUN this still shows the old committed values; mfhi/mflo are stalled then
  assign rdata = rd_sel ? hi_q : lo_q;

  // The hazard unit must keep MD ops out of E while busy; flag violations in sim
  a_no_start_busy: assert property (@(posedge clk) disable iff (!reset_n)
    !(start_ok && (state_q == ST_RUN)))
    else $warning("mdu_ctrl: start while busy dropped");

  a_no_we_busy: assert property (@(posedge clk) disable iff (!reset_n)
    !(md_we && !start && ((md_op == MD_MTHI) || (md_op == MD_MTLO)) && (state_q == ST_RUN)))
    else $warning("mdu_ctrl: mthi/mtlo while busy dropped");

  logic unused_commit;
  assign unused_commit = commit;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed test-plan sequences plus a few random ops,
// with expected {hi,lo} pairs queued at start and compared when busy drops.
module tb_mdu_ctrl;
  import md_defs::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  md_op;
  logic        md_we;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;
  md_state_e   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .md_op     (md_op),
    .md_we     (md_we),
    .a         (a),
    .b         (b),
    .rd_sel    (rd_sel),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .rdata     (rdata),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic wait_cyc();
    @(posedge clk);
    #1;
  endtask

  // Independent reference built on 64-bit integer arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    case (op)
      3'd0: begin q = sa * sb; return q; end
      3'd1: begin p = ua * ub; return p; end
      3'd2: begin
        if (bv == 32'd0) return {mdl_hi, mdl_lo};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (bv == 32'd0) return {mdl_hi, mdl_lo};
        p = ua / ub;
        return {ua[31:0] % bv, p[31:0]};
      end
      default: return {mdl_hi, mdl_lo};
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op);
    return (op <= 3'd1) ? MC : DC;
  endfunction

  // Issue one start, push expectation, measure busy window, pop and compare on completion
  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    int busy_cyc;
    logic [63:0] e;
    logic [63:0] old;
    old = {hi, lo};
    e = model(op, av, bv);
    exp_q.push_back(e);
    {mdl_hi, mdl_lo} = e;
    start = 1'b1; md_op = op; a = av; b = bv;
    wait_cyc();
    start = 1'b0; md_op = MD_NONE;
    busy_cyc = 0;
    while (busy && busy_cyc < 40) begin
      if (busy_cyc == 1) check("run_holds_old", {hi, lo}, old);
      busy_cyc++;
      wait_cyc();
    end
    check("busy_len", 64'(busy_cyc), 64'(lat(op)));
    check("busy_done", {63'd0, busy}, 64'd0);
    if (exp_q.size() != 0) check("result", {hi, lo}, exp_q.pop_front());
  endtask

  task automatic md_write(input logic [2:0] op, input logic [31:0] av);
    md_we = 1'b1; md_op = op; a = av;
    wait_cyc();
    md_we = 1'b0; md_op = MD_NONE;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; md_op = MD_NONE; md_we = 1'b0;
    a = '0; b = '0; rd_sel = 1'b0;
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_state", {63'd0, dbg_state}, {63'd0, ST_IDLE});
    reset_n = 1'b1;
    wait_cyc();

    // Directed test-plan operations
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    check("divu_const", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

    // mthi then divide by zero: HI/LO untouched
    md_write(MD_MTHI, 32'h1234_5678);
    mdl_hi = 32'h1234_5678;
    check("mthi", {32'd0, hi}, {32'd0, 32'h1234_5678});
    run_op(3'd3, 32'd99, 32'd0);
    check("div0_hilo", {hi, lo}, {32'h1234_5678, mdl_lo});
    rd_sel = 1'b1; #1;
    check("rdata_hi", {32'd0, rdata}, {32'd0, 32'h1234_5678});
    rd_sel = 1'b0; #1;
    check("rdata_lo", {32'd0, rdata}, {32'd0, mdl_lo});
    md_write(MD_MTLO, 32'hCAFE_F00D);
    mdl_lo = 32'hCAFE_F00D;
    check("mtlo", {32'd0, lo}, {32'd0, 32'hCAFE_F00D});

    // Illegal start op is ignored
    start = 1'b1; md_op = 3'd6; a = 32'h1; b = 32'h1;
    wait_cyc();
    start = 1'b0; md_op = MD_NONE;
    check("bad_op_idle", {63'd0, busy}, 64'd0);

    // start and md_we together: start wins
    exp_q.push_back(model(3'd0, 32'd7, 32'd6));
    {mdl_hi, mdl_lo} = model(3'd0, 32'd7, 32'd6);
    start = 1'b1; md_we = 1'b1; md_op = 3'd0; a = 32'd7; b = 32'd6;
    wait_cyc();
    start = 1'b0; md_we = 1'b0; md_op = MD_NONE;
    check("both_busy", {63'd0, busy}, 64'd1);
    check("both_no_we", {32'd0, hi}, {32'd0, 32'h1234_5678});
    for (int i = 0; i < 40 && busy; i++) wait_cyc();
    check("both_result", {hi, lo}, exp_q.pop_front());

    // Hazards during a mult: mtlo at cycle 2, second start at cycle 3
    exp_q.push_back(model(3'd0, 32'd1000, 32'd3));
    {mdl_hi, mdl_lo} = model(3'd0, 32'd1000, 32'd3);
    start = 1'b1; md_op = 3'd0; a = 32'd1000; b = 32'd3;
    wait_cyc();
    start = 1'b0; md_op = MD_NONE;
    for (int c = 1; c <= MC; c++) begin
      check("hz_busy", {63'd0, busy}, 64'd1);
      md_we = (c == 2); start = (c == 3);
      md_op = (c == 2) ? MD_MTLO : ((c == 3) ? 3'd2 : MD_NONE);
      a = 32'hBAD0_BAD0; b = 32'd5;
      wait_cyc();
      md_we = 1'b0; start = 1'b0; md_op = MD_NONE;
    end
    check("hz_done", {63'd0, busy}, 64'd0);
    check("hz_result", {hi, lo}, exp_q.pop_front());
    wait_cyc();
    check("hz_no_second", {63'd0, busy}, 64'd0);

    // Reset at cycle 3 of a div
    start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd7;
    wait_cyc();
    start = 1'b0; md_op = MD_NONE;
    wait_cyc(); wait_cyc();
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    #10 reset_n = 1'b1;
    wait_cyc();
    run_op(3'd0, 32'd12345, 32'hFFFF_FFF0);

    // A few random ops against the model
    for (int i = 0; i < 6; i++) begin
      run_op(3'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit with its sequencing controller, sitting in the E stage beside the ALU. Accepts one MULT/MULTU/DIV/DIVU per start pulse and runs a fixed-latency busy window. Commits results to the architectural HI/LO registers at the end of that window. Handles MTHI/MTLO writes and serves MFHI/MFLO reads. Its start/busy outputs feed the D-stage hazard unit, which holds any MD-class instruction in D while start|busy is high.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request, valid only with md_op in 0..3
md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 none
md_we  input  1  qualifies md_op 4/5 (mthi/mtlo write)
a  input  32  rs operand, already forwarded
b  input  32  rt operand, already forwarded
rd_sel  input  1  0 = read LO, 1 = read HI
busy  output  1  operation in progress
hi  output  32  architectural HI
lo  output  32  architectural LO
rdata  output  32  rd_sel ? hi : lo, combinational, for mfhi/mflo

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending regs=0. Deassertion is synchronised by the top level; no sync logic in this block.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, cnt counts down.
- IDLE, start=1 at edge k:
  - Capture results from a and b into pend_hi and pend_lo.
  - Load cnt = (op is mult/multu ? MULT_CYCLES : DIV_CYCLES) - 1.
  - Go to RUN.
  - busy is 1 in cycles k+1 .. k+N, where N is the op latency.
- RUN:
  - cnt != 0: decrement cnt.
  - cnt == 0: write hi<=pend_hi and lo<=pend_lo, go to IDLE.
  - New hi/lo are visible in cycle k+N+1, the same cycle busy drops.
- Arithmetic:
  - mult: signed 32x32 to 64 bits, hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 to 64 bits, split the same way.
  - div: signed, lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned, lo=quotient, hi=remainder.
  - Special case: div with a=0x80000000 and b=0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (div/divu with b=0): the full busy window still runs, and hi/lo stay unchanged at commit.
- mthi/mtlo (md_we=1, md_op 4/5, IDLE only): write a into hi or lo at the next edge. Zero latency, busy stays 0.
- Simultaneous events:
  - start while busy: ignored (hazard unit guarantees it cannot happen), and a sim assertion flags it.
  - md_we while busy: ignored, also asserted.
  - start and md_we in the same cycle: start wins, md_we ignored.
  - start with md_op not in 0..3: ignored.
- Reset mid-RUN: operation abandoned, hi/lo=0, busy=0 immediately.
- rdata during RUN returns the old committed hi/lo (hazard unit stalls mfhi/mflo, so this is never consumed).

Decomposition:
- Shared package md_defs:
  - md_op encodings (MD_MULT..MD_MTLO, MD_NONE).
  - State encoding (ST_IDLE, ST_RUN).
  - Default latency constants.
- One sub-module, mdu_arith: purely combinational. Takes a, b, md_op and returns res_hi, res_lo and div0.
- mdu_ctrl holds the FSM, counter, pending and HI/LO registers.

Test Plan:
- mult, a=0xFFFFFFFE (-2), b=3, start at cycle 0 -> busy=1 cycles 1..5, busy=0 cycle 6, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
- div, a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; repeat as divu -> lo=0x7FFFFFFC, hi=1.
- mthi 0x12345678 then divu with b=0 -> busy 10 cycles, hi stays 0x12345678, lo unchanged; rdata with rd_sel=1 gives 0x12345678.
- Hazards:
  - start mult, then a second start at cycle 3 -> ignored, the first result commits at cycle 6.
  - mtlo at cycle 2 -> lo not written.
- Reset: reset_n low at cycle 3 of a div -> busy=0, hi=lo=0 immediately; after release, a new mult completes normally.
